mdu_iterative: RTL and testbench

- Iterative multiply/divide unit in the Execute stage, directly downstream of the register file.
- Consumes the rs/rt read data (src_a/src_b) for MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers and supports MTHI/MTLO.
- Exposes busy so the hazard logic stalls dependent MFHI/MFLO or MDU instructions.

---
 rtl/mdu_iterative.sv | 146 ++++++++++++++
 tb/tb_mdu_iterative.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, sign fix at the end.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;

  // Signed ops work on magnitudes; op[0] set means unsigned.
  assign a_neg = ~op[0] & src_a[WIDTH-1];
  assign b_neg = ~op[0] & src_b[WIDTH-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -src_b : src_b;

  // Multiplier sits in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign div_next  = rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          b_d       = mag_b;
          a_raw_d   = src_a;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          state_d   = S_CALC;
        end else begin
          if (mthi) hi_d = src_a;
          if (mtlo) lo_d = src_a;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed cases plus random traffic, checked every cycle
// against an arithmetic model of HI/LO/busy/done.
module tb_mdu_iterative;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic [W-1:0]  hi, lo;
  logic          busy, done;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference result {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: an accepted op delivers its result W+1 edges after the start edge.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  int          m_cnt;
  logic [63:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end else if (start) begin
        m_pend <= ref_result(op, src_a, src_b);
        m_busy <= 1'b1;
        m_cnt  <= W + 1;
      end else begin
        if (mthi) m_hi <= src_a;
        if (mtlo) m_lo <= src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc busy", 64'(busy), 64'(m_busy));
      chk("cyc done", 64'(done), 64'(m_done));
      chk("cyc hi", 64'(hi), 64'(m_hi));
      chk("cyc lo", 64'(lo), 64'(m_lo));
    end
  end

  // disturb: 1 = mtlo mid-CALC, 2 = start mid-CALC, 3 = mthi together with start
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int disturb);
    int k, busy_cnt;
    logic [31:0] hi_before;
    @(negedge clk);
    hi_before = m_hi;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (disturb == 3) mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    src_a = 32'h5A5A_0F0F;
    src_b = 32'h0000_0003;
    k = 1;
    busy_cnt = busy ? 1 : 0;
    if (disturb == 3) chk({name, " hi kept"}, 64'(hi), 64'(hi_before));
    while (!done && k < 100) begin
      if (k == 10 && disturb == 1) mtlo = 1'b1;
      if (k == 10 && disturb == 2) start = 1'b1;
      if (k == 11) begin mtlo = 1'b0; start = 1'b0; end
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
    end
    chk({name, " latency"}, 64'(k - 1), 64'(W + 1));
    chk({name, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    chk({name, " done width"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw_done;
    // Pin the model with hand-computed values.
    chk("ref mult", ref_result(2'd0, 32'hFFFF_FFFD, 32'h5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("ref multu", ref_result(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("ref div", ref_result(2'd2, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref div ovf", ref_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    chk("ref divu0", ref_result(2'd3, 32'h1234, 32'h0), 64'h0000_1234_FFFF_FFFF);

    repeat (2) @(negedge clk);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst done", 64'(done), 64'd0);

    mthi = 1'b1; src_a = 32'hAAAA_5555;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi hi", 64'(hi), 64'hAAAA_5555);

    // Reset mid-CALC.
    op = 2'd1; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort no done", 64'(saw_done), 64'd0);

    run_op("mult", 2'd0, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
    run_op("div", 2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 2);
    run_op("divu by0", 2'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 0);
    run_op("div by0", 2'd2, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
    run_op("div rem", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 3);

    // Random traffic; the per-cycle compare checks everything.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      src_a = pick();
      src_b = pick();
      mthi  = ($urandom_range(0, 5) == 0);
      mtlo  = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
